// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// One quotient bit per cycle. The result is held while EX keeps start_i
// high, so a stalled pipeline can resample it on any cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_e;

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     w_q, w_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 n1_q, n1_d;      // dividend was negative (signed op)
  logic                 n2_q, n2_d;      // divisor was negative (signed op)
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       diff_s;
  logic [WIDTH-1:0]     op1_mag_s, op2_mag_s;
  logic [WIDTH-1:0]     quot_s, rem_s;

  // Next-state, datapath step and result formatting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    dvsr_d   = dvsr_q;
    n1_d     = n1_q;
    n2_d     = n2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // Trial subtraction; the top bit is the borrow that decides restore vs keep.
    diff_s = {1'b0, w_q[2*WIDTH-1:WIDTH]} - {1'b0, dvsr_q};

    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      op1_mag_s = twos_neg(opdata1_i);
    end else begin
      op1_mag_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      op2_mag_s = twos_neg(opdata2_i);
    end else begin
      op2_mag_s = opdata2_i;
    end

    // Sign fixup: quotient negative when signs differ, remainder follows dividend.
    if (n1_q ^ n2_q) begin
      quot_s = twos_neg(w_q[WIDTH-1:0]);
    end else begin
      quot_s = w_q[WIDTH-1:0];
    end
    if (n1_q) begin
      rem_s = twos_neg(w_q[2*WIDTH:WIDTH+1]);
    end else begin
      rem_s = w_q[2*WIDTH:WIDTH+1];
    end

    case (state_q)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_d = ST_BY_ZERO;
          end else begin
            state_d = ST_ON;
            cnt_d   = {CW{1'b0}};
            w_d     = {{WIDTH{1'b0}}, op1_mag_s, 1'b0};
            dvsr_d  = op2_mag_s;
            n1_d    = signed_div_i & opdata1_i[WIDTH-1];
            n2_d    = signed_div_i & opdata2_i[WIDTH-1];
          end
        end else begin
          state_d = ST_FREE;
        end
      end
      ST_BY_ZERO: begin
        // Divide by zero yields an all-zero result with no trap.
        state_d  = ST_END;
        w_d      = {(2*WIDTH+1){1'b0}};
        result_d = {(2*WIDTH){1'b0}};
        ready_d  = 1'b1;
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q != CW'(WIDTH)) begin
          if (diff_s[WIDTH]) begin
            w_d = {w_q[2*WIDTH-1:0], 1'b0};
          end else begin
            w_d = {diff_s[WIDTH-1:0], w_q[WIDTH-1:0], 1'b1};
          end
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          result_d = {rem_s, quot_s};
          ready_d  = 1'b1;
          state_d  = ST_END;
          cnt_d    = {CW{1'b0}};
        end
      end
      ST_END: begin
        // Hold the result until EX drops its request.
        if (!start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d  = ST_FREE;
        cnt_d    = {CW{1'b0}};
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FREE;
      cnt_q    <= {CW{1'b0}};
      w_q      <= {(2*WIDTH+1){1'b0}};
      dvsr_q   <= {WIDTH{1'b0}};
      n1_q     <= 1'b0;
      n2_q     <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      dvsr_q   <= dvsr_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~annul_i & ~ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider, signed and unsigned, for the EX stage of the 5-stage pipeline.
- Driven by EX when a DIV/DIVU instruction is present.
- Produces the {HI,LO} result and the EX stall request that the pipeline stall controller turns into stall vector 6'b001111.
- Holds its result until EX withdraws the start request, so the stalled pipeline can resample it safely.

Parameters:
- WIDTH, 32: operand width. result_o is 2*WIDTH. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk input 1: rising-edge clock.
- rst input 1: reset; synchronous, active-high.
- signed_div_i input 1: 1 = signed division (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i input WIDTH: dividend; sampled at start.
- opdata2_i input WIDTH: divisor; sampled at start.
- start_i input 1: division request from EX. Held high until ready_o is seen.
- annul_i input 1: cancel request (flush/exception). Takes priority over start_i.
- result_o output 2*WIDTH: {remainder, quotient}. Upper half goes to HI, lower half to LO.
- ready_o output 1: result valid.
- stallreq_o output 1: combinational, equal to start_i & ~annul_i & ~ready_o. Feeds the ctrl EX stall input.

Behaviour:
- Reset: when rst=1 at an edge, the following are cleared:
  - state = FREE, counter = 0, work reg W = 0;
  - result_o = 0, ready_o = 0.
  - This applies in any state, including mid-division.
- Working register W is 2*WIDTH+1 bits. Iteration step:
  - diff = {1'b0, W[2W-1:W]} - {1'b0, divisor}, a (WIDTH+1)-bit subtraction.
  - If diff[WIDTH]=1: W <= {W[2W-1:0], 1'b0}.
  - Else: W <= {diff[W-1:0], W[W-1:0], 1'b1}.
- State FREE (ready_o=0):
  - If start_i & ~annul_i and opdata2_i == 0: go to BY_ZERO.
  - If start_i & ~annul_i and opdata2_i != 0: go to ON, counter = 0, and latch the operands:
    - If signed_div_i=1, negative operands are converted to two's-complement magnitude.
    - W = {WIDTH'b0, |dividend|, 1'b0}.
    - Latch the original operand signs.
  - Otherwise: remain in FREE.
- State BY_ZERO: next edge goes to END with W = 0. Result is 0; no trap is raised.
- State ON:
  - If annul_i=1: go to FREE, counter = 0, ready_o stays 0.
  - Else if counter != WIDTH: perform one iteration step, counter += 1.
  - Else (counter == WIDTH), on this edge:
    - quotient = W[WIDTH-1:0]; remainder = W[2W:WIDTH+1].
    - If signed: negate the quotient when the operand signs differ; negate the remainder when the dividend is negative.
    - result_o = {remainder, quotient}, ready_o = 1, go to END, counter = 0.
- State END:
  - While start_i=1: hold result_o and ready_o=1. Operand changes are ignored.
  - When start_i=0: next edge goes to FREE, ready_o = 0, result_o = 0.
- Latency, counting edge E0 as the edge that samples start_i in FREE:
  - Normal division: iterations occur on E1..E32; ready_o=1 after E33, i.e. 33 cycles of stallreq_o.
  - Divide-by-zero: ready_o=1 after E1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no exception).
- Simultaneous start_i and annul_i in FREE: no start; stallreq_o = 0.
- annul_i in END or BY_ZERO has no effect. EX clears start_i on a flush, which returns the block to FREE.

Test Plan:
- Unsigned 100 / 7, start held:
  - stallreq_o=1 for 33 cycles.
  - After E33: ready_o=1, result_o = {32'd2, 32'd14}.
  - Drop start: ready_o=0 and result_o=0 on the next edge.
- Signed -7 / 2: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- Signed 7 / -2: result_o = {32'h00000001, 32'hFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF: result_o = {32'h0, 32'h80000000}.
- Divisor 0: BY_ZERO, then ready_o=1 after E1 with result_o=0; stallreq_o=1 for exactly one cycle.
- annul_i=1 at E10 of an active division:
  - Block returns to FREE and ready_o never asserts.
  - With start_i held high after the annul, a new division starts on the next edge and completes in full 33-cycle latency.
- rst=1 at E15 of an active division: all outputs 0 after that edge and state = FREE. A new 100 / 7 afterwards returns {2, 14}.
